// File: rtl/health_tracker_if.sv
// Bundles the round-control inputs and the health/result outputs of the
// health tracker so the game top level and the bench wire one object.
interface health_tracker_if;
  logic       start_i;
  logic       hit1_i;
  logic       hit2_i;
  logic [1:0] health1_o;
  logic [1:0] health2_o;
  logic       game_over_o;
  logic [1:0] winner_o;
  logic [1:0] hit_ack_o;

  // Driver side: collision logic / round control
  modport master (
    output start_i, hit1_i, hit2_i,
    input  health1_o, health2_o, game_over_o, winner_o, hit_ack_o
  );

  // Tracker side
  modport slave (
    input  start_i, hit1_i, hit2_i,
    output health1_o, health2_o, game_over_o, winner_o, hit_ack_o
  );
endinterface

// File: rtl/health_tracker.sv
// Player health tracker: counts hits per player with a per-player
// invincibility cooldown and runs the idle/play/over round state machine.
//
// state  | meaning
// IDLE   | waiting for start; health held at MAX_HEALTH, hits ignored
// PLAY   | round running; rising-edge hits decrement health
// OVER   | round ended; health frozen, winner valid, cooldowns cleared
module health_tracker #(
  parameter int MAX_HEALTH   = 3,
  parameter int HIT_COOLDOWN = 25000000
) (
  input logic               clk_i,
  input logic               rst_i,
  health_tracker_if.slave   bus
);

  localparam int CD_W = (HIT_COOLDOWN < 1) ? 1 : $clog2(HIT_COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(HIT_COOLDOWN);
  localparam logic [1:0] HMAX = 2'(MAX_HEALTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t          state_q, state_d;
  logic            hit1_dly_q, hit2_dly_q;
  logic [1:0]      health1_q, health1_d;
  logic [1:0]      health2_q, health2_d;
  logic [CD_W-1:0] cd1_q, cd1_d;
  logic [CD_W-1:0] cd2_q, cd2_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      winner_q, winner_d;
  logic [1:0]      hit_ack_q, hit_ack_d;

  logic rise1, rise2;

  assign rise1 = bus.hit1_i & ~hit1_dly_q;
  assign rise2 = bus.hit2_i & ~hit2_dly_q;

  // State, health, cooldown and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      hit1_dly_q  <= 1'b0;
      hit2_dly_q  <= 1'b0;
      health1_q   <= HMAX;
      health2_q   <= HMAX;
      cd1_q       <= '0;
      cd2_q       <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      hit_ack_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      hit1_dly_q  <= bus.hit1_i;
      hit2_dly_q  <= bus.hit2_i;
      health1_q   <= health1_d;
      health2_q   <= health2_d;
      cd1_q       <= cd1_d;
      cd2_q       <= cd2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      hit_ack_q   <= hit_ack_d;
    end
  end

  // Next-state logic: hit acceptance and round transitions
  always_comb begin
    state_d     = state_q;
    health1_d   = health1_q;
    health2_d   = health2_q;
    cd1_d       = (cd1_q != '0) ? cd1_q - 1'b1 : cd1_q;
    cd2_d       = (cd2_q != '0) ? cd2_q - 1'b1 : cd2_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    hit_ack_d   = 2'b00;

    case (state_q)
      S_IDLE: begin
        health1_d   = HMAX;
        health2_d   = HMAX;
        game_over_d = 1'b0;
        winner_d    = 2'b00;
        if (bus.start_i) state_d = S_PLAY;
      end

      S_PLAY: begin
        if (rise1 && cd1_q == '0) begin
          health1_d    = (health1_q != 2'd0) ? health1_q - 2'd1 : 2'd0;
          hit_ack_d[0] = 1'b1;
          cd1_d        = CD_LOAD;
        end
        if (rise2 && cd2_q == '0) begin
          health2_d    = (health2_q != 2'd0) ? health2_q - 2'd1 : 2'd0;
          hit_ack_d[1] = 1'b1;
          cd2_d        = CD_LOAD;
        end
        // Decided on post-decrement health so the killing hit ends the round
        if (health1_d == 2'd0 || health2_d == 2'd0) begin
          state_d     = S_OVER;
          game_over_d = 1'b1;
          if (health1_d == 2'd0 && health2_d == 2'd0) winner_d = 2'b11;
          else if (health1_d == 2'd0)                 winner_d = 2'b10;
          else                                        winner_d = 2'b01;
        end
      end

      S_OVER: begin
        cd1_d = '0;
        cd2_d = '0;
        if (bus.start_i) begin
          health1_d   = HMAX;
          health2_d   = HMAX;
          game_over_d = 1'b0;
          winner_d    = 2'b00;
          state_d     = S_PLAY;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.health1_o   = health1_q;
  assign bus.health2_o   = health2_q;
  assign bus.game_over_o = game_over_q;
  assign bus.winner_o    = winner_q;
  assign bus.hit_ack_o   = hit_ack_q;

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker with a short cooldown (4 clocks).
module tb_health_tracker;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ack1_cnt = 0;
  int   ack2_cnt = 0;

  health_tracker_if bus ();

  health_tracker #(.MAX_HEALTH(3), .HIT_COOLDOWN(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One clock: outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    ack1_cnt += int'(bus.hit_ack_o[0]);
    ack2_cnt += int'(bus.hit_ack_o[1]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Single-cycle pulse on hit2 followed by enough idle clocks to clear cooldown
  task automatic pulse2();
    bus.hit2_i = 1'b1;
    tick();
    bus.hit2_i = 1'b0;
    ticks(5);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.hit1_i  = 1'b0;
    bus.hit2_i  = 1'b0;
    ticks(2);
    rst = 1'b0;
    check("rst_h1", 32'(bus.health1_o), 3);
    check("rst_h2", 32'(bus.health2_o), 3);
    check("rst_go", 32'(bus.game_over_o), 0);
    check("rst_win", 32'(bus.winner_o), 0);
    check("rst_ack", 32'(bus.hit_ack_o), 0);

    // Hits in IDLE are ignored
    ack1_cnt = 0;
    bus.hit1_i = 1'b1;
    tick();
    bus.hit1_i = 1'b0;
    ticks(2);
    check("idle_h1", 32'(bus.health1_o), 3);
    check("idle_ack", 32'(ack1_cnt), 0);

    // Start, then hit1 held for 10 clocks counts once
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("play_go", 32'(bus.game_over_o), 0);
    ack1_cnt = 0;
    bus.hit1_i = 1'b1;
    tick();
    check("hold_first_h1", 32'(bus.health1_o), 2);
    check("hold_first_ack", 32'(bus.hit_ack_o), 1);
    ticks(9);
    bus.hit1_i = 1'b0;
    tick();
    check("hold_h1", 32'(bus.health1_o), 2);
    check("hold_ack_cnt", 32'(ack1_cnt), 1);

    // Cooldown: hit2 edges at k, k+2, k+6
    bus.hit2_i = 1'b1;
    tick();
    check("cd_k_ack", 32'(bus.hit_ack_o), 2);
    check("cd_k_h2", 32'(bus.health2_o), 2);
    bus.hit2_i = 1'b0;
    tick();
    bus.hit2_i = 1'b1;
    tick();
    check("cd_k2_ack", 32'(bus.hit_ack_o), 0);
    check("cd_k2_h2", 32'(bus.health2_o), 2);
    bus.hit2_i = 1'b0;
    ticks(3);
    bus.hit2_i = 1'b1;
    tick();
    check("cd_k6_ack", 32'(bus.hit_ack_o), 2);
    check("cd_k6_h2", 32'(bus.health2_o), 1);
    bus.hit2_i = 1'b0;
    tick();

    // Bring player 1 down to 1, then simultaneous hits -> draw
    bus.hit1_i = 1'b1;
    tick();
    check("pre_draw_h1", 32'(bus.health1_o), 1);
    bus.hit1_i = 1'b0;
    ticks(5);
    bus.hit1_i = 1'b1;
    bus.hit2_i = 1'b1;
    tick();
    check("draw_ack", 32'(bus.hit_ack_o), 3);
    check("draw_h1", 32'(bus.health1_o), 0);
    check("draw_h2", 32'(bus.health2_o), 0);
    check("draw_go", 32'(bus.game_over_o), 1);
    check("draw_win", 32'(bus.winner_o), 3);
    bus.hit1_i = 1'b0;
    bus.hit2_i = 1'b0;
    ticks(2);
    check("over_hold_go", 32'(bus.game_over_o), 1);

    // Restart from OVER
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("restart_h1", 32'(bus.health1_o), 3);
    check("restart_h2", 32'(bus.health2_o), 3);
    check("restart_win", 32'(bus.winner_o), 0);
    check("restart_go", 32'(bus.game_over_o), 0);

    // Knockout of player 2, with a start in PLAY that must be ignored
    pulse2();
    check("ko1_h2", 32'(bus.health2_o), 2);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("start_in_play_h2", 32'(bus.health2_o), 2);
    pulse2();
    check("ko2_h2", 32'(bus.health2_o), 1);
    bus.hit2_i = 1'b1;
    tick();
    bus.hit2_i = 1'b0;
    check("ko3_h2", 32'(bus.health2_o), 0);
    check("ko3_go", 32'(bus.game_over_o), 1);
    check("ko3_win", 32'(bus.winner_o), 1);
    ack1_cnt = 0;
    ticks(2);
    for (int i = 0; i < 2; i++) begin
      bus.hit1_i = 1'b1;
      tick();
      bus.hit1_i = 1'b0;
      ticks(5);
    end
    check("over_h1", 32'(bus.health1_o), 3);
    check("over_ack", 32'(ack1_cnt), 0);
    check("over_win", 32'(bus.winner_o), 1);

    // New round, one hit, then reset while cooldown still running
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.hit1_i = 1'b1;
    tick();
    check("mid_h1", 32'(bus.health1_o), 2);
    bus.hit1_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_h1", 32'(bus.health1_o), 3);
    check("mrst_h2", 32'(bus.health2_o), 3);
    check("mrst_go", 32'(bus.game_over_o), 0);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.hit1_i = 1'b1;
    tick();
    check("mrst_hit_ack", 32'(bus.hit_ack_o), 1);
    check("mrst_hit_h1", 32'(bus.health1_o), 2);
    bus.hit1_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
